// File: rtl/toy_valu_drain_ctrl_if.sv
// Bundle of the drain controller's command, systolic-array and register-file signals.
// The master side issues commands and supplies rows; the slave side is the controller.
interface toy_valu_drain_ctrl_if #(
    parameter int V_REG_WIDTH = 512,
    parameter int CNT_WIDTH   = 6
);
    logic                   cmd_vld;
    logic                   cmd_rdy;
    logic [CNT_WIDTH-1:0]   cmd_rows;
    logic [4:0]             cmd_rd_base;
    logic                   cmd_relu;
    logic [V_REG_WIDTH-1:0] sa_din;
    logic                   sa_shift_en;
    logic [4:0]             reg_index;
    logic                   reg_wr_en;
    logic                   reg_wr_rdy;
    logic [V_REG_WIDTH-1:0] reg_data;
    logic                   busy;
    logic                   done;

    modport master (
        output cmd_vld, cmd_rows, cmd_rd_base, cmd_relu, sa_din, reg_wr_rdy,
        input  cmd_rdy, sa_shift_en, reg_index, reg_wr_en, reg_data, busy, done
    );

    modport slave (
        input  cmd_vld, cmd_rows, cmd_rd_base, cmd_relu, sa_din, reg_wr_rdy,
        output cmd_rdy, sa_shift_en, reg_index, reg_wr_en, reg_data, busy, done
    );
endinterface

// File: rtl/toy_valu_drain_ctrl.sv
// Drains N rows from the systolic array head, optionally ReLUs each lane, and writes
// them to consecutive vector registers through a one-entry output stage.
module toy_valu_drain_ctrl #(
    parameter int V_REG_WIDTH = 512,
    parameter int LANE_WIDTH  = 32,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    toy_valu_drain_ctrl_if.slave  io
);

    localparam int NUM_LANES = V_REG_WIDTH / LANE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   rem_q;
    logic [4:0]             next_idx_q;
    logic                   relu_q;
    logic                   stage_vld_q;
    logic [4:0]             stage_idx_q;
    logic [V_REG_WIDTH-1:0] stage_data_q;
    logic                   cmd_rdy_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   cmd_fire;
    logic                   accepted;
    logic                   load;
    logic [V_REG_WIDTH-1:0] relu_data;

    assign cmd_fire = io.cmd_vld & cmd_rdy_q;
    assign accepted = stage_vld_q & io.reg_wr_rdy;
    // A new row may enter the stage when it is empty or being emptied this cycle.
    assign load     = (state_q == ST_DRAIN) & (rem_q != '0) & (~stage_vld_q | io.reg_wr_rdy);

    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        relu_data = io.sa_din;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (relu_q && io.sa_din[l*LANE_WIDTH + LANE_WIDTH - 1]) begin
                relu_data[l*LANE_WIDTH +: LANE_WIDTH] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = (io.cmd_rows == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((rem_q == '0) && accepted) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the wide data stage is reset too, because reg_data must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            next_idx_q   <= '0;
            relu_q       <= 1'b0;
            stage_vld_q  <= 1'b0;
            stage_idx_q  <= '0;
            stage_data_q <= '0;
            cmd_rdy_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_rdy_q <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);

            if (cmd_fire) begin
                rem_q      <= io.cmd_rows;
                next_idx_q <= io.cmd_rd_base;
                relu_q     <= io.cmd_relu;
            end

            if (load) begin
                stage_vld_q  <= 1'b1;
                stage_idx_q  <= next_idx_q;
                stage_data_q <= relu_data;
                next_idx_q   <= next_idx_q + 5'd1;
                rem_q        <= rem_q - CNT_WIDTH'(1);
            end else if (accepted) begin
                stage_vld_q  <= 1'b0;
            end
        end
    end

    assign io.cmd_rdy     = cmd_rdy_q;
    assign io.sa_shift_en = load;
    assign io.reg_wr_en   = stage_vld_q;
    assign io.reg_index   = stage_idx_q;
    assign io.reg_data    = stage_data_q;
    assign io.busy        = busy_q;
    assign io.done        = done_q;

endmodule

// File: tb/tb_toy_valu_drain_ctrl.sv
// Directed bench for the drain controller: a row-stream model feeds sa_din and a
// negedge monitor logs shifts, accepted writes and done pulses relative to command accept.
module tb_toy_valu_drain_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    toy_valu_drain_ctrl_if #(.V_REG_WIDTH(512), .CNT_WIDTH(6)) bus ();

    toy_valu_drain_ctrl #(
        .V_REG_WIDTH(512),
        .LANE_WIDTH (32),
        .CNT_WIDTH  (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus.slave)
    );

    // Systolic-array head model: row at sa_ptr, advanced by each shift.
    logic [511:0] sa_mem [0:63];
    logic [5:0]   sa_ptr = '0;
    assign bus.sa_din = sa_mem[sa_ptr];
    always @(posedge clk) if (bus.sa_shift_en) sa_ptr <= sa_ptr + 6'd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor logs, cycles numbered so that cycle 1 follows the accept edge.
    int           acc_edge = 0;
    int           shift_q[$];
    int           wr_q[$];
    int           idx_q[$];
    logic [511:0] data_q[$];
    int           done_q[$];
    bit           stalled_prev = 1'b0;
    logic [4:0]   prev_idx;
    logic [511:0] prev_data;

    always @(negedge clk) begin
        int rel;
        rel = cyc - acc_edge;
        if (bus.sa_shift_en) shift_q.push_back(rel);
        if (bus.reg_wr_en && bus.reg_wr_rdy) begin
            wr_q.push_back(rel);
            idx_q.push_back(int'(bus.reg_index));
            data_q.push_back(bus.reg_data);
        end
        if (bus.done) done_q.push_back(rel);
        if (stalled_prev && bus.reg_wr_en) begin
            check("stall_idx_hold", 512'(bus.reg_index), 512'(prev_idx));
            check("stall_data_hold", bus.reg_data, prev_data);
        end
        stalled_prev = bus.reg_wr_en && !bus.reg_wr_rdy;
        prev_idx     = bus.reg_index;
        prev_data    = bus.reg_data;
    end

    // Expectations for the current command.
    int           exp_shift[$];
    int           exp_wr[$];
    int           exp_idx[$];
    logic [511:0] exp_data[$];
    int           exp_done;

    function automatic logic [511:0] mk(input logic [31:0] lane);
        return {16{lane}};
    endfunction

    task automatic clear_logs();
        shift_q.delete(); wr_q.delete(); idx_q.delete(); data_q.delete(); done_q.delete();
    endtask

    task automatic issue(input int rows, input int base, input bit relu);
        int n;
        n = 0;
        while (!bus.cmd_rdy && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("cmd_rdy_before_issue", 512'(bus.cmd_rdy), 512'(1));
        bus.cmd_vld     = 1'b1;
        bus.cmd_rows    = 6'(rows);
        bus.cmd_rd_base = 5'(base);
        bus.cmd_relu    = relu;
        @(posedge clk); #1;
        acc_edge    = cyc - 1;
        bus.cmd_vld = 1'b0;
        // A command offered while busy must be ignored.
        bus.cmd_rows = 6'd9;
    endtask

    task automatic drain(input string name, input int rows, input int base, input bit relu,
                         input int stall_at, input int stall_len);
        clear_logs();
        issue(rows, base, relu);
        bus.cmd_vld = 1'b1;
        for (int k = 0; k < 80; k++) begin
            int r;
            r = cyc - acc_edge;
            bus.reg_wr_rdy = !(r >= stall_at && r < stall_at + stall_len);
            @(negedge clk); #1;
            if (done_q.size() != 0) break;
            @(posedge clk); #1;
        end
        bus.cmd_vld    = 1'b0;
        bus.reg_wr_rdy = 1'b1;
        @(posedge clk); #1;
        check({name, "_rdy_back"}, 512'(bus.cmd_rdy), 512'(1));
        check({name, "_busy_clear"}, 512'(bus.busy), 512'(0));
        check({name, "_n_shift"}, 512'(shift_q.size()), 512'(exp_shift.size()));
        for (int i = 0; i < exp_shift.size() && i < shift_q.size(); i++)
            check($sformatf("%s_shift_cyc%0d", name, i), 512'(shift_q[i]), 512'(exp_shift[i]));
        check({name, "_n_write"}, 512'(wr_q.size()), 512'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
            check($sformatf("%s_wr_cyc%0d", name, i), 512'(wr_q[i]), 512'(exp_wr[i]));
            check($sformatf("%s_wr_idx%0d", name, i), 512'(idx_q[i]), 512'(exp_idx[i]));
            check($sformatf("%s_wr_data%0d", name, i), data_q[i], exp_data[i]);
        end
        check({name, "_n_done"}, 512'(done_q.size()), 512'(1));
        if (done_q.size() != 0) check({name, "_done_cyc"}, 512'(done_q[0]), 512'(exp_done));
    endtask

    initial begin
        int p;
        for (int i = 0; i < 64; i++) sa_mem[i] = '0;
        rst_n          = 1'b0;
        bus.cmd_vld    = 1'b0;
        bus.cmd_rows   = '0;
        bus.cmd_rd_base = '0;
        bus.cmd_relu   = 1'b0;
        bus.reg_wr_rdy = 1'b1;

        // Reset state.
        #12;
        check("rst_cmd_rdy", 512'(bus.cmd_rdy), 512'(0));
        check("rst_shift", 512'(bus.sa_shift_en), 512'(0));
        check("rst_wr_en", 512'(bus.reg_wr_en), 512'(0));
        check("rst_busy", 512'(bus.busy), 512'(0));
        check("rst_done", 512'(bus.done), 512'(0));
        check("rst_data", bus.reg_data, 512'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_cmd_rdy", 512'(bus.cmd_rdy), 512'(1));

        // Four rows, pass-through, full throughput.
        p = int'(sa_ptr);
        exp_data.delete();
        for (int k = 0; k < 4; k++) begin
            sa_mem[p+k] = mk(32'h1111_0000 + 32'(k)) ^ {480'd0, 32'h8000_0000};
            exp_data.push_back(mk(32'h1111_0000 + 32'(k)) ^ {480'd0, 32'h8000_0000});
        end
        exp_shift = '{1, 2, 3, 4};
        exp_wr    = '{2, 3, 4, 5};
        exp_idx   = '{3, 4, 5, 6};
        exp_done  = 6;
        drain("basic", 4, 3, 1'b0, 0, 0);

        // ReLU per signed lane.
        p = int'(sa_ptr);
        sa_mem[p]   = {{12{32'h0000_0001}}, 32'h8000_0000, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFB};
        sa_mem[p+1] = {8{32'h7FFF_FFFF, 32'h8000_0001}};
        exp_data  = '{{{12{32'h0000_0001}}, 32'h0, 32'h0000_0007, 32'h0, 32'h0},
                      {8{32'h7FFF_FFFF, 32'h0000_0000}}};
        exp_shift = '{1, 2};
        exp_wr    = '{2, 3};
        exp_idx   = '{0, 1};
        exp_done  = 4;
        drain("relu", 2, 0, 1'b1, 0, 0);

        // Write port stalls for cycles 3 and 4.
        p = int'(sa_ptr);
        exp_data.delete();
        for (int k = 0; k < 3; k++) begin
            sa_mem[p+k] = mk(32'hC0DE_0000 + 32'(k));
            exp_data.push_back(mk(32'hC0DE_0000 + 32'(k)));
        end
        exp_shift = '{1, 2, 5};
        exp_wr    = '{2, 5, 6};
        exp_idx   = '{10, 11, 12};
        exp_done  = 7;
        drain("stall", 3, 10, 1'b0, 3, 2);

        // Destination index wraps 31 -> 0.
        p = int'(sa_ptr);
        exp_data.delete();
        for (int k = 0; k < 4; k++) begin
            sa_mem[p+k] = mk(32'hF000_00A0 + 32'(k));
            exp_data.push_back(mk(32'hF000_00A0 + 32'(k)));
        end
        exp_shift = '{1, 2, 3, 4};
        exp_wr    = '{2, 3, 4, 5};
        exp_idx   = '{30, 31, 0, 1};
        exp_done  = 6;
        drain("wrap", 4, 30, 1'b0, 0, 0);

        // Zero-row command.
        exp_shift.delete(); exp_wr.delete(); exp_idx.delete(); exp_data.delete();
        exp_done = 1;
        drain("zero", 0, 5, 1'b0, 0, 0);

        // Reset after two of five rows written.
        p = int'(sa_ptr);
        for (int k = 0; k < 5; k++) sa_mem[p+k] = mk(32'h5A5A_0000 + 32'(k));
        clear_logs();
        issue(5, 20, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_shift", 512'(bus.sa_shift_en), 512'(0));
        check("mid_rst_wr_en", 512'(bus.reg_wr_en), 512'(0));
        check("mid_rst_index", 512'(bus.reg_index), 512'(0));
        check("mid_rst_data", bus.reg_data, 512'(0));
        check("mid_rst_busy", 512'(bus.busy), 512'(0));
        check("mid_rst_cmd_rdy", 512'(bus.cmd_rdy), 512'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_n_writes", 512'(wr_q.size()), 512'(2));
        check("rst_n_shifts", 512'(shift_q.size()), 512'(3));
        check("rst_n_done", 512'(done_q.size()), 512'(0));

        p = int'(sa_ptr);
        sa_mem[p] = mk(32'h0BAD_F00D);
        exp_data  = '{mk(32'h0BAD_F00D)};
        exp_shift = '{1};
        exp_wr    = '{2};
        exp_idx   = '{7};
        exp_done  = 3;
        drain("after_rst", 1, 7, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
